// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock, start/done handshake
// Optional early divide-by-zero completion: SEQ_DIVIDER_DIV_ZERO_EN
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dsor_q, dsor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    logic             zero_q, zero_d;
`endif

    // work_q starts as the dividend; its MSB feeds the partial remainder while
    // quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   shifted;
    logic             qbit;

    always_comb begin
        trial   = {prem_q, work_q[WIDTH-1]} - {2'b00, dsor_q};
        shifted = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
        qbit    = ~trial[WIDTH+1];

        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dsor_d  = dsor_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
        zero_d  = zero_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    count_d = '0;
                    prem_d  = '0;
                    work_d  = dividend;
                    dsor_d  = divisor;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
                    zero_d  = (divisor == '0);
`endif
                end
            end
            S_CALC: begin
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
                if (zero_q) begin
                    quo_d   = '1;
                    rem_d   = work_q;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else
`endif
                begin
                    prem_d  = qbit ? trial[WIDTH:0] : shifted;
                    work_d  = {work_q[WIDTH-2:0], qbit};
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        quo_d   = {work_q[WIDTH-2:0], qbit};
                        rem_d   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            prem_q  <= '0;
            work_q  <= '0;
            dsor_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dsor_q  <= dsor_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
